vram_scroller: RTL

VRAM_SCROLLER -- requirements
Module: vram_scroller

---
 rtl/vram_scroller.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/vram_scroller.sv
// Scroll-up / scroll-down / clear-screen / clear-line engine for a {y,x}-addressed character VRAM.
// Build macro VSCROLL_FILL_PORT_EN adds an i_fill input that replaces the FILL parameter as blank code.
module vram_scroller #(
    parameter int         COLS   = 60,
    parameter int         ROWS   = 17,
    parameter int         X_BITS = 6,
    parameter int         Y_BITS = 5,
    parameter logic [7:0] FILL   = 8'h20,
    parameter int         RD_LAT = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [1:0]               i_cmd,
    input  logic [Y_BITS-1:0]        i_n,
`ifdef VSCROLL_FILL_PORT_EN
    input  logic [7:0]               i_fill,
`endif
    output logic                     o_busy,
    output logic                     o_done,
    output logic [X_BITS+Y_BITS-1:0] o_vram_addr,
    output logic                     o_vram_ce,
    output logic                     o_vram_w,
    output logic [7:0]               o_vram_din,
    input  logic [7:0]               i_vram_dout
);

    localparam logic [Y_BITS-1:0] LAST_ROW = Y_BITS'(ROWS - 1);
    localparam logic [Y_BITS-1:0] ROWS_Y   = Y_BITS'(ROWS);
    localparam logic [Y_BITS:0]   ROWS_W   = (Y_BITS + 1)'(ROWS);
    localparam logic [X_BITS-1:0] LAST_COL = X_BITS'(COLS - 1);
    localparam logic [Y_BITS-1:0] ONE_Y    = Y_BITS'(1);
    localparam logic [X_BITS-1:0] ONE_X    = X_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_FILL,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [Y_BITS-1:0]         row_q, row_d;
    logic [X_BITS-1:0]         col_q, col_d;
    logic [Y_BITS-1:0]         n_q, n_d;
    logic                      up_q, up_d;
    logic [Y_BITS-1:0]         last_copy_q, last_copy_d;
    logic [Y_BITS-1:0]         fill_lo_q, fill_lo_d;
    logic [Y_BITS-1:0]         fill_hi_q, fill_hi_d;
    logic [7:0]                fill_q, fill_d;
    logic [X_BITS+Y_BITS-1:0]  addr_q, addr_d;
    logic                      ce_q, ce_d;
    logic                      w_q, w_d;
    logic [7:0]                din_q, din_d;
    logic                      copy_wr_q, copy_wr_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [7:0]                fill_in;
    logic                      n_big;
    logic [Y_BITS-1:0]         src_row;

`ifdef VSCROLL_FILL_PORT_EN
    assign fill_in = i_fill;
`else
    assign fill_in = FILL;
`endif

    assign n_big = {1'b0, i_n} >= ROWS_W;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        n_d         = n_q;
        up_d        = up_q;
        last_copy_d = last_copy_q;
        fill_lo_d   = fill_lo_q;
        fill_hi_d   = fill_hi_q;
        fill_d      = fill_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (i_start) begin
                    n_d       = i_n;
                    fill_d    = fill_in;
                    col_d     = '0;
                    row_d     = '0;
                    fill_lo_d = '0;
                    fill_hi_d = LAST_ROW;
                    case (i_cmd)
                        2'b00, 2'b01: begin
                            if (i_n == '0) begin
                                state_d = S_DONE;
                            end else if (n_big) begin
                                state_d = S_FILL;
                            end else if (i_cmd == 2'b00) begin
                                // Ascending copy: sources lie below the destination, never yet written.
                                state_d     = S_READ;
                                up_d        = 1'b1;
                                last_copy_d = LAST_ROW - i_n;
                                fill_lo_d   = ROWS_Y - i_n;
                            end else begin
                                state_d     = S_READ;
                                up_d        = 1'b0;
                                row_d       = LAST_ROW;
                                last_copy_d = i_n;
                                fill_hi_d   = i_n - ONE_Y;
                            end
                        end
                        2'b10: state_d = S_FILL;
                        default: begin
                            if (n_big) begin
                                state_d = S_DONE;
                            end else begin
                                state_d   = S_FILL;
                                row_d     = i_n;
                                fill_lo_d = i_n;
                                fill_hi_d = i_n;
                            end
                        end
                    endcase
                end
            end
            S_READ:  state_d = (RD_LAT == 2) ? S_WAIT : S_WRITE;
            S_WAIT:  state_d = S_WRITE;
            S_WRITE: begin
                state_d = S_READ;
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    if (row_q == last_copy_q) begin
                        state_d = S_FILL;
                        row_d   = fill_lo_q;
                    end else begin
                        row_d = up_q ? row_q + ONE_Y : row_q - ONE_Y;
                    end
                end else begin
                    col_d = col_q + ONE_X;
                end
            end
            S_FILL: begin
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    if (row_q == fill_hi_q) begin
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q + ONE_Y;
                    end
                end else begin
                    col_d = col_q + ONE_X;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they leave the flops aligned with it.
    always_comb begin
        src_row   = up_d ? row_d + n_d : row_d - n_d;
        addr_d    = '0;
        ce_d      = 1'b0;
        w_d       = 1'b0;
        din_d     = '0;
        copy_wr_d = 1'b0;
        case (state_d)
            S_READ: begin
                ce_d   = 1'b1;
                addr_d = {src_row, col_d};
            end
            S_WRITE: begin
                ce_d      = 1'b1;
                w_d       = 1'b1;
                addr_d    = {row_d, col_d};
                copy_wr_d = 1'b1;
            end
            S_FILL: begin
                ce_d   = 1'b1;
                w_d    = 1'b1;
                addr_d = {row_d, col_d};
                din_d  = fill_d;
            end
            default: ;
        endcase
        busy_d = (state_d == S_READ) || (state_d == S_WAIT) ||
                 (state_d == S_WRITE) || (state_d == S_FILL);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            n_q         <= '0;
            up_q        <= 1'b0;
            last_copy_q <= '0;
            fill_lo_q   <= '0;
            fill_hi_q   <= '0;
            fill_q      <= '0;
            addr_q      <= '0;
            ce_q        <= 1'b0;
            w_q         <= 1'b0;
            din_q       <= '0;
            copy_wr_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            n_q         <= n_d;
            up_q        <= up_d;
            last_copy_q <= last_copy_d;
            fill_lo_q   <= fill_lo_d;
            fill_hi_q   <= fill_hi_d;
            fill_q      <= fill_d;
            addr_q      <= addr_d;
            ce_q        <= ce_d;
            w_q         <= w_d;
            din_q       <= din_d;
            copy_wr_q   <= copy_wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_vram_addr = addr_q;
    assign o_vram_ce   = ce_q;
    assign o_vram_w    = w_q;
    // Copy writes forward the read data straight through, so each cell costs RD_LAT+1 cycles.
    assign o_vram_din  = copy_wr_q ? i_vram_dout : din_q;

endmodule
